triangle_dispatcher: RTL and testbench

Per-frame scheduler between the projected-triangle FIFO and the rasterizer. It pops one triangle at a time through the FIFO read port and absorbs the on-chip RAM read latency. It computes a screen-clamped bounding box, presents triangle plus box on a valid/ready handshake, and signals frame completion once the geometry stage is done and the FIFO is drained.

---
 rtl/triangle_dispatcher.sv | 172 +++++++++++++++++
 tb/tb_triangle_dispatcher.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_dispatcher.sv
// Per-frame triangle scheduler between the projected-triangle FIFO and the rasterizer.
// Define TRI_BBOX_CULL_EN to drop degenerate and fully off-screen triangles in CALC.
module triangle_dispatcher #(
   parameter int RD_LAT   = 1,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  frame_start,
   input  logic                  producer_done,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   input  logic [2:0][1:0][9:0]  fifo_tri,
   output logic                  rast_valid,
   input  logic                  rast_ready,
   output logic [2:0][1:0][9:0]  rast_tri,
   output logic [9:0]            bbox_xmin,
   output logic [9:0]            bbox_xmax,
   output logic [9:0]            bbox_ymin,
   output logic [9:0]            bbox_ymax,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           tri_count,
   output logic [15:0]           cull_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_READ, S_WAIT, S_CALC, S_ISSUE, S_DONE
   } state_t;

   localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [9:0]  X_LIM     = 10'(SCREEN_W - 1);
   localparam logic [9:0]  Y_LIM     = 10'(SCREEN_H - 1);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   state_t               state_q, state_d;
   logic                 done_q, done_d;
   logic [1:0]           wait_q, wait_d;
   logic [2:0][1:0][9:0] tri_q, tri_d;
   logic [9:0]           xmin_q, xmin_d, xmax_q, xmax_d;
   logic [9:0]           ymin_q, ymin_d, ymax_q, ymax_d;
   logic [15:0]          tri_count_q, tri_count_d;
   logic [15:0]          cull_count_q, cull_count_d;

   logic [9:0] xmin_raw, xmax_raw, ymin_raw, ymax_raw;
   logic       cull;

   // Unsigned min/max over the held triangle; only max is clamped to the screen.
   always_comb begin
      xmin_raw = tri_q[0][0];
      xmax_raw = tri_q[0][0];
      ymin_raw = tri_q[0][1];
      ymax_raw = tri_q[0][1];
      for (int v = 1; v < 3; v++) begin
         if (tri_q[v][0] < xmin_raw) xmin_raw = tri_q[v][0];
         if (tri_q[v][0] > xmax_raw) xmax_raw = tri_q[v][0];
         if (tri_q[v][1] < ymin_raw) ymin_raw = tri_q[v][1];
         if (tri_q[v][1] > ymax_raw) ymax_raw = tri_q[v][1];
      end
`ifdef TRI_BBOX_CULL_EN
      cull = ({22'd0, xmin_raw} >= 32'(SCREEN_W)) ||
             ({22'd0, ymin_raw} >= 32'(SCREEN_H)) ||
             (xmin_raw == xmax_raw) ||
             (ymin_raw == ymax_raw);
`else
      cull = 1'b0;
`endif
   end

   always_comb begin
      state_d      = state_q;
      done_d       = done_q;
      wait_d       = wait_q;
      tri_d        = tri_q;
      xmin_d       = xmin_q;
      xmax_d       = xmax_q;
      ymin_d       = ymin_q;
      ymax_d       = ymax_q;
      tri_count_d  = tri_count_q;
      cull_count_d = cull_count_q;

      if (state_q != S_IDLE && producer_done) done_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               tri_count_d  = '0;
               cull_count_d = '0;
               done_d       = 1'b0;
               state_d      = S_POLL;
            end
         end
         // A non-empty FIFO wins over a pending done so the frame is fully drained.
         S_POLL: begin
            if (!fifo_empty)                   state_d = S_READ;
            else if (done_q || producer_done)  state_d = S_DONE;
         end
         S_READ: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               tri_d   = fifo_tri;
               state_d = S_CALC;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_CALC: begin
            xmin_d = xmin_raw;
            ymin_d = ymin_raw;
            xmax_d = (xmax_raw > X_LIM) ? X_LIM : xmax_raw;
            ymax_d = (ymax_raw > Y_LIM) ? Y_LIM : ymax_raw;
            if (cull) begin
               if (cull_count_q != CNT_MAX) cull_count_d = cull_count_q + 16'd1;
               state_d = S_POLL;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rast_ready) begin
               if (tri_count_q != CNT_MAX) tri_count_d = tri_count_q + 16'd1;
               state_d = S_POLL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         done_q       <= 1'b0;
         wait_q       <= '0;
         tri_q        <= '0;
         xmin_q       <= '0;
         xmax_q       <= '0;
         ymin_q       <= '0;
         ymax_q       <= '0;
         tri_count_q  <= '0;
         cull_count_q <= '0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         wait_q       <= wait_d;
         tri_q        <= tri_d;
         xmin_q       <= xmin_d;
         xmax_q       <= xmax_d;
         ymin_q       <= ymin_d;
         ymax_q       <= ymax_d;
         tri_count_q  <= tri_count_d;
         cull_count_q <= cull_count_d;
      end
   end

   assign fifo_r_en  = (state_q == S_READ);
   assign rast_valid = (state_q == S_ISSUE);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign rast_tri   = tri_q;
   assign bbox_xmin  = xmin_q;
   assign bbox_xmax  = xmax_q;
   assign bbox_ymin  = ymin_q;
   assign bbox_ymax  = ymax_q;
   assign tri_count  = tri_count_q;
   assign cull_count = cull_count_q;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Self-checking bench for triangle_dispatcher: behavioural FIFO with read latency,
// scoreboard of expected (triangle, bbox) pairs popped at each rasterizer handshake.
module tb_triangle_dispatcher;

   localparam int RD_LAT   = 1;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [2:0][1:0][9:0] tri_t;
   typedef struct {
      tri_t       t;
      logic [9:0] xmin, xmax, ymin, ymax;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset_n, frame_start, producer_done, fifo_empty, rast_ready;
   logic        fifo_r_en, rast_valid, busy, frame_done;
   tri_t        fifo_tri, rast_tri;
   logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
   logic [15:0] tri_count, cull_count;

   tri_t fifo_q[$];
   exp_t sb_q[$];
   int   hs_cyc[$];
   tri_t stage [RD_LAT];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   issued   = 0;
   int   valid_cycles = 0;
   int   cyc      = 0;

   triangle_dispatcher #(.RD_LAT(RD_LAT), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .producer_done(producer_done),
      .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_tri(fifo_tri),
      .rast_valid(rast_valid), .rast_ready(rast_ready), .rast_tri(rast_tri),
      .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
      .busy(busy), .frame_done(frame_done), .tri_count(tri_count), .cull_count(cull_count)
   );

   always #5 Clk = ~Clk;

   function automatic tri_t make_tri(input int x0, input int y0, input int x1,
                                     input int y1, input int x2, input int y2);
      tri_t t;
      t[0][0] = 10'(x0); t[0][1] = 10'(y0);
      t[1][0] = 10'(x1); t[1][1] = 10'(y1);
      t[2][0] = 10'(x2); t[2][1] = 10'(y2);
      return t;
   endfunction

   task automatic push_tri(input tri_t t, input bit expect_issue, input int xmin,
                           input int xmax, input int ymin, input int ymax);
      exp_t e;
      fifo_q.push_back(t);
      fifo_empty = 1'b0;
      if (expect_issue) begin
         e.t = t; e.xmin = 10'(xmin); e.xmax = 10'(xmax); e.ymin = 10'(ymin); e.ymax = 10'(ymax);
         sb_q.push_back(e);
      end
   endtask

   // One clock: scoreboard compare on handshake, then advance the FIFO model #1 after the edge.
   task automatic tick();
      logic rd;
      exp_t e;
      rd = fifo_r_en;
      if (rast_valid) valid_cycles++;
      if (rast_valid && rast_ready) begin
         issued++;
         hs_cyc.push_back(cyc);
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL sb_unexpected: issued tri %h with no expected entry", rast_tri);
         end else begin
            e = sb_q.pop_front();
            if ({rast_tri, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !==
                {e.t, e.xmin, e.xmax, e.ymin, e.ymax}) begin
               n_fail++;
               $display("[TB] FAIL sb_issue: got tri %h bbox %0d,%0d,%0d,%0d expected tri %h bbox %0d,%0d,%0d,%0d",
                        rast_tri, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
                        e.t, e.xmin, e.xmax, e.ymin, e.ymax);
            end
         end
      end
      @(posedge Clk);
      #1;
      cyc++;
      for (int i = RD_LAT - 1; i > 0; i--) stage[i] = stage[i-1];
      if (rd) begin
         if (fifo_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL empty_read: fifo_r_en got 1 expected 0 while FIFO empty");
            stage[0] = '0;
         end else begin
            stage[0] = fifo_q.pop_front();
         end
      end
      fifo_tri   = stage[RD_LAT-1];
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic wait_frame_done(input string name);
      int k;
      k = 0;
      while (frame_done !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s_timeout: frame_done got %b expected 1 within 200 cycles", name, frame_done);
      end
   endtask

   task automatic test_reset();
      int k;
      Reset_n = 1'b0;
      tick(); tick();
      n_checks++;
      if ({fifo_r_en, rast_valid, busy, frame_done, rast_tri, bbox_xmin, bbox_xmax,
           bbox_ymin, bbox_ymax, tri_count, cull_count} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got busy=%b valid=%b tri_count=%0d expected all 0",
                  busy, rast_valid, tri_count);
      end
      Reset_n = 1'b1;
      tick();
      push_tri(make_tri(7, 8, 9, 10, 11, 12), 1'b0, 0, 0, 0, 0);
      rast_ready  = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      k = 0;
      while (rast_valid !== 1'b1 && k < 20) begin tick(); k++; end
      n_checks++;
      if (rast_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_reach_issue: rast_valid got %b expected 1", rast_valid);
      end
      Reset_n = 1'b0;
      tick(); tick();
      n_checks++;
      if ({fifo_r_en, rast_valid, busy, frame_done, rast_tri, bbox_xmin, bbox_xmax,
           bbox_ymin, bbox_ymax, tri_count, cull_count} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_issue: got valid=%b busy=%b tri=%h bbox_xmin=%0d expected all 0",
                  rast_valid, busy, rast_tri, bbox_xmin);
      end
      Reset_n = 1'b1;
      fifo_q.delete();
      sb_q.delete();
      for (int i = 0; i < RD_LAT; i++) stage[i] = '0;
      fifo_tri   = '0;
      fifo_empty = 1'b1;
      tick();
      n_checks++;
      if (rast_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_release: valid=%b busy=%b expected 0 0", rast_valid, busy);
      end
   endtask

   task automatic test_single();
      int base;
      rast_ready = 1'b1;
      push_tri(make_tri(10, 20, 100, 5, 50, 300), 1'b1, 10, 100, 5, 300);
      base = issued;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n_checks++;
      if (fifo_r_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_poll: r_en=%b busy=%b expected 0 1", fifo_r_en, busy);
      end
      tick();
      n_checks++;
      if (fifo_r_en !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_read: fifo_r_en got %b expected 1", fifo_r_en);
      end
      tick();
      n_checks++;
      if (fifo_r_en !== 1'b0 || rast_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_wait: r_en=%b valid=%b expected 0 0", fifo_r_en, rast_valid);
      end
      tick();
      n_checks++;
      if (rast_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_calc: rast_valid got %b expected 0", rast_valid);
      end
      tick();
      n_checks++;
      if (rast_valid !== 1'b1 || {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !==
          {10'd10, 10'd100, 10'd5, 10'd300}) begin
         n_fail++;
         $display("[TB] FAIL single_issue: valid=%b bbox %0d,%0d,%0d,%0d expected 1 bbox 10,100,5,300",
                  rast_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
      end
      tick();
      n_checks++;
      if (tri_count !== 16'd1 || rast_valid !== 1'b0 || issued - base != 1) begin
         n_fail++;
         $display("[TB] FAIL single_after: tri_count=%0d valid=%b issued=%0d expected 1 0 1",
                  tri_count, rast_valid, issued - base);
      end
   endtask

   task automatic test_frame_done();
      producer_done = 1'b1;
      tick();
      producer_done = 1'b0;
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL done_pulse: frame_done got %b expected 1", frame_done);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || tri_count !== 16'd1) begin
         n_fail++;
         $display("[TB] FAIL done_after: frame_done=%b busy=%b tri_count=%0d expected 0 0 1",
                  frame_done, busy, tri_count);
      end
   endtask

   task automatic test_stall();
      int   k;
      tri_t t;
      t = make_tri(600, 470, 700, 10, 620, 500);
      rast_ready = 1'b0;
      push_tri(t, 1'b1, 600, 639, 10, 479);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      k = 0;
      while (rast_valid !== 1'b1 && k < 20) begin tick(); k++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (rast_valid !== 1'b1 || rast_tri !== t || tri_count !== 16'd0 ||
             {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== {10'd600, 10'd639, 10'd10, 10'd479}) begin
            n_fail++;
            $display("[TB] FAIL stall_hold%0d: valid=%b tri=%h bbox %0d,%0d,%0d,%0d count=%0d expected 1 %h 600,639,10,479 0",
                     i, rast_valid, rast_tri, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, tri_count, t);
         end
         tick();
      end
      rast_ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (tri_count !== 16'd1 || rast_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL stall_release: tri_count=%0d valid=%b expected 1 0", tri_count, rast_valid);
      end
      producer_done = 1'b1;
      tick();
      producer_done = 1'b0;
      wait_frame_done("stall");
      tick();
   endtask

   task automatic test_back_to_back();
      int base, hs0;
      rast_ready = 1'b1;
      push_tri(make_tri(1, 2, 3, 4, 5, 6), 1'b1, 1, 5, 2, 6);
      push_tri(make_tri(639, 479, 0, 0, 320, 240), 1'b1, 0, 639, 0, 479);
      push_tri(make_tri(1023, 1023, 100, 200, 50, 60), 1'b1, 50, 639, 60, 479);
      base = issued;
      hs0  = hs_cyc.size();
      frame_start = 1'b1;
      tick();
      frame_start   = 1'b0;
      producer_done = 1'b1;
      tick();
      producer_done = 1'b0;
      wait_frame_done("b2b");
      n_checks++;
      if (issued - base != 3 || tri_count !== 16'd3 || sb_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_count: issued=%0d tri_count=%0d pending=%0d expected 3 3 0",
                  issued - base, tri_count, sb_q.size());
      end
      n_checks++;
      if (hs_cyc.size() < hs0 + 3) begin
         n_fail++;
         $display("[TB] FAIL b2b_gap: handshakes got %0d expected 3", hs_cyc.size() - hs0);
      end else if (hs_cyc[hs0+1] - hs_cyc[hs0] != 4 + RD_LAT ||
                   hs_cyc[hs0+2] - hs_cyc[hs0+1] != 4 + RD_LAT) begin
         n_fail++;
         $display("[TB] FAIL b2b_gap: gaps %0d,%0d expected %0d", hs_cyc[hs0+1] - hs_cyc[hs0],
                  hs_cyc[hs0+2] - hs_cyc[hs0+1], 4 + RD_LAT);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL b2b_idle: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_cull();
      int base, vbase;
      int exp_tri, exp_cull;
      rast_ready = 1'b1;
`ifdef TRI_BBOX_CULL_EN
      push_tri(make_tri(5, 5, 5, 40, 5, 90), 1'b0, 0, 0, 0, 0);
      push_tri(make_tri(650, 10, 700, 20, 800, 30), 1'b0, 0, 0, 0, 0);
      exp_tri = 0; exp_cull = 2;
`else
      push_tri(make_tri(5, 5, 5, 40, 5, 90), 1'b1, 5, 5, 5, 90);
      push_tri(make_tri(650, 10, 700, 20, 800, 30), 1'b1, 650, 639, 10, 30);
      exp_tri = 2; exp_cull = 0;
`endif
      base  = issued;
      vbase = valid_cycles;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      producer_done = 1'b1;
      tick();
      producer_done = 1'b0;
      wait_frame_done("cull");
      n_checks++;
      if (tri_count !== 16'(exp_tri) || cull_count !== 16'(exp_cull) || issued - base != exp_tri) begin
         n_fail++;
         $display("[TB] FAIL cull_counts: tri=%0d cull=%0d issued=%0d expected %0d %0d %0d",
                  tri_count, cull_count, issued - base, exp_tri, exp_cull, exp_tri);
      end
      n_checks++;
      if ((valid_cycles - vbase) != exp_tri) begin
         n_fail++;
         $display("[TB] FAIL cull_valid: rast_valid cycles got %0d expected %0d",
                  valid_cycles - vbase, exp_tri);
      end
      tick();
   endtask

   initial begin
      Reset_n       = 1'b0;
      frame_start   = 1'b0;
      producer_done = 1'b0;
      fifo_empty    = 1'b1;
      fifo_tri      = '0;
      rast_ready    = 1'b0;
      for (int i = 0; i < RD_LAT; i++) stage[i] = '0;
      #1;
      test_reset();
      test_single();
      test_frame_done();
      test_stall();
      test_back_to_back();
      test_cull();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
